kron_stream_reader: RTL and testbench
=====================================

KRON_STREAM_READER -- requirements
Module: kron_stream_reader

Interface
- REQ-001: Parameter word_size, default 32, is the element width in bits.
- REQ-002: Parameter Amatrixrownum, default 2, is the row count of the A factor.
- REQ-003: Parameter Amatrixcolnum, default 2, is the column count of the A factor.
- REQ-004: Parameter Bmatrixrownum, default 2, is the row count of the B factor.
- REQ-005: Parameter Bmatrixcolnum, default 2, is the column count of the B factor.
- REQ-006: Derived values SHALL be R = Amatrixrownum*Bmatrixrownum, C = Amatrixcolnum*Bmatrixcolnum and N = R*C.
- REQ-007: clk  input  1  is the single clock; all state changes on its rising edge.
- REQ-008: rst  input  1  is the asynchronous, active-high reset.
- REQ-009: TP  input  N*word_size  is the flat Kronecker product vector, element (0,0) in the MSBs.
- REQ-010: tp_valid  input  1  SHALL indicate that TP is valid.
- REQ-011: tp_ready  output  1  SHALL indicate that the block accepts TP.
- REQ-012: elem_data  output  word_size  is the current element.
- REQ-013: elem_row  output  max(1,$clog2(R))  is the row index of elem_data.
- REQ-014: elem_col  output  max(1,$clog2(C))  is the column index of elem_data.
- REQ-015: elem_valid  output  1  SHALL indicate that elem_data, elem_row, elem_col and elem_last are valid.
- REQ-016: elem_ready  input  1  SHALL indicate that the downstream consumer accepts the element.
- REQ-017: elem_last  output  1  SHALL be high only on element (R-1,C-1).

Function
- REQ-018: The FSM SHALL have two states: IDLE (tp_ready=1, elem_valid=0) and STREAM (elem_valid=1).
- REQ-019: A TP transfer is tp_valid&&tp_ready at a rising edge; on a transfer in IDLE the block SHALL register TP, clear row and col to 0, and enter STREAM.
- REQ-020: First-element latency SHALL be 1 cycle: elem_valid goes high in the cycle after the TP transfer.
- REQ-021: Element (r,c) SHALL be TP[N*word_size-1-(r*C+c)*word_size -: word_size], taken from the registered copy of TP.
- REQ-022: Elements SHALL be emitted in row-major order.
- REQ-023: An element transfer is elem_valid&&elem_ready; on each transfer col SHALL advance, wrapping from C-1 to 0 with row incrementing.
- REQ-024: A transfer of the elem_last element SHALL return the FSM to IDLE, with row and col cleared.
- REQ-025: While elem_valid=1 and elem_ready=0, all elem_* outputs SHALL hold stable.
- REQ-026: Throughput SHALL be one element per cycle while elem_ready=1.
- REQ-027: Changes on TP while in STREAM SHALL NOT affect output.
- REQ-028: When N=1, the single element SHALL have elem_last=1.

Reset
- REQ-029: While rst=1, the block SHALL force state IDLE, row=0, col=0, tp_ready=0, elem_valid=0, elem_last=0, elem_data=0, elem_row=0 and elem_col=0.
- REQ-030: tp_ready SHALL rise in the first cycle after rst deasserts.
- REQ-031: A reset asserted mid-stream SHALL discard the matrix being streamed, and that matrix SHALL NOT resume after reset.

Configuration
- REQ-032: Macro KRON_READER_PRELOAD_EN SHALL control a one-entry shadow TP register.
- REQ-033: With KRON_READER_PRELOAD_EN defined, tp_ready SHALL equal !shadow_full in every state.
- REQ-034: With KRON_READER_PRELOAD_EN defined and the shadow full, an elem_last transfer SHALL move the shadow into the active register and stay in STREAM at (0,0), giving zero bubble cycles.
- REQ-035: With KRON_READER_PRELOAD_EN defined, a TP transfer and an elem_last transfer in the same cycle SHALL make TP the next active matrix directly.
- REQ-036: With KRON_READER_PRELOAD_EN undefined, there SHALL be no shadow, tp_ready=1 only in IDLE, and consecutive matrices SHALL be separated by at least one idle cycle.

Verification (default parameters: R=4, C=4, N=16)
- REQ-037: Basic stream: load TP with words 1..16 (MSB first) and hold elem_ready=1 -> elem_data=1..16 on 16 consecutive cycles, (row,col) from (0,0) to (3,3), elem_last only with data 16.
- REQ-038: Backpressure: drop elem_ready for 3 cycles while the element with data 5 is presented -> data=5 and (row,col)=(1,0) hold for 3 cycles, then the sequence continues at 6.
- REQ-039: Reset mid-stream: assert rst while element 7 is presented -> all outputs 0, then tp_ready=1 in the cycle after release; a new TP restarts the stream at (0,0).
- REQ-040: Preload (macro on): offer a second TP (words 101..116) during streaming -> 32 consecutive valid cycles, 16 followed directly by 101, elem_last high twice.
- REQ-041: Non-square (Amatrixrownum=1, Amatrixcolnum=2, Bmatrixrownum=3, Bmatrixcolnum=1; R=3, C=2): load TP=1..6 -> (row,col) sequence (0,0),(0,1),(1,0),(1,1),(2,0),(2,1), elem_last with data 6.
- REQ-042: Macro off: tp_valid held high continuously -> exactly one idle cycle with tp_ready=1 between consecutive 16-element bursts.

Source files
------------

// File: rtl/kron_stream_reader.sv
// rtl/kron_stream_reader.sv - streams a flat Kronecker product vector element by element in row-major order (optional shadow TP register under KRON_READER_PRELOAD_EN)
module kron_stream_reader #(
    parameter int word_size     = 32,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2,
    localparam int R  = Amatrixrownum * Bmatrixrownum,
    localparam int C  = Amatrixcolnum * Bmatrixcolnum,
    localparam int N  = R * C,
    localparam int RW = (R > 1) ? $clog2(R) : 1,
    localparam int CW = (C > 1) ? $clog2(C) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*word_size-1:0] TP,
    input  logic                   tp_valid,
    output logic                   tp_ready,
    output logic [word_size-1:0]   elem_data,
    output logic [RW-1:0]          elem_row,
    output logic [CW-1:0]          elem_col,
    output logic                   elem_valid,
    input  logic                   elem_ready,
    output logic                   elem_last
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [N*word_size-1:0] tp_q, tp_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   live_q;
`ifdef KRON_READER_PRELOAD_EN
    logic [N*word_size-1:0] shadow_q, shadow_d;
    logic                   shadow_full_q, shadow_full_d;
`endif

    logic                 tp_xfer;
    logic                 elem_xfer;
    logic                 at_last;
    logic [word_size-1:0] elem_word;
    int                   idx;

    // Holds tp_ready low during reset and for the edge that releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) live_q <= 1'b0;
        else     live_q <= 1'b1;
    end

    // Handshakes and the element currently addressed by (row, col).
    always_comb begin
`ifdef KRON_READER_PRELOAD_EN
        tp_ready = live_q && !shadow_full_q;
`else
        tp_ready = live_q && (state_q == IDLE);
`endif
        elem_valid = (state_q == STREAM);
        tp_xfer    = tp_valid && tp_ready;
        elem_xfer  = elem_valid && elem_ready;
        at_last    = (row_q == RW'(R - 1)) && (col_q == CW'(C - 1));
        idx        = int'(row_q) * C + int'(col_q);
        elem_word  = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == i) elem_word = tp_q[N*word_size-1-i*word_size -: word_size];
        end
        elem_data = elem_valid ? elem_word : '0;
        elem_row  = row_q;
        elem_col  = col_q;
        elem_last = elem_valid && at_last;
    end

    // Next-state: load in IDLE, walk row-major in STREAM, chain or stop after the last element.
    always_comb begin
        state_d = state_q;
        tp_d    = tp_q;
        row_d   = row_q;
        col_d   = col_q;
`ifdef KRON_READER_PRELOAD_EN
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (tp_xfer) begin
                    tp_d    = TP;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (elem_xfer) begin
                    if (at_last) begin
                        row_d = '0;
                        col_d = '0;
`ifdef KRON_READER_PRELOAD_EN
                        if (shadow_full_q) begin
                            tp_d          = shadow_q;
                            shadow_full_d = 1'b0;
                        end else if (tp_xfer) begin
                            tp_d = TP;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else if (col_q == CW'(C - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
`ifdef KRON_READER_PRELOAD_EN
                if (tp_xfer && !(elem_xfer && at_last)) begin
                    shadow_d      = TP;
                    shadow_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, active matrix and position registers; reset discards any matrix in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tp_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
`ifdef KRON_READER_PRELOAD_EN
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tp_q    <= tp_d;
            row_q   <= row_d;
            col_q   <= col_d;
`ifdef KRON_READER_PRELOAD_EN
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
`endif
        end
    end

endmodule

// File: tb/tb_kron_stream_reader.sv
// tb/tb_kron_stream_reader.sv - randomized self-checking bench for kron_stream_reader against a queue model
module tb_kron_stream_reader;

    localparam int W = 32;
    localparam int R = 4;
    localparam int C = 4;
    localparam int N = 16;

    typedef struct {
        logic [W-1:0] d;
        int           r;
        int           c;
        bit           last;
    } elem_t;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] tp;
    logic           tp_valid;
    logic           tp_ready;
    logic [W-1:0]   elem_data;
    logic [1:0]     elem_row;
    logic [1:0]     elem_col;
    logic           elem_valid;
    logic           elem_ready;
    logic           elem_last;

    logic [6*W-1:0] ns_tp;
    logic           ns_tv;
    logic           ns_tp_ready;
    logic [W-1:0]   ns_data;
    logic [1:0]     ns_row;
    logic [0:0]     ns_col;
    logic           ns_valid;
    logic           ns_er;
    logic           ns_last;

    int           n_vec;
    int           n_err;
    elem_t        q[$];
    logic [W-1:0] words [N];
    bit           seen_valid;

    kron_stream_reader #(.word_size(W)) u_dut (
        .clk(clk), .rst(rst), .TP(tp), .tp_valid(tp_valid), .tp_ready(tp_ready),
        .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_last(elem_last)
    );

    kron_stream_reader #(
        .word_size(W), .Amatrixrownum(1), .Amatrixcolnum(2),
        .Bmatrixrownum(3), .Bmatrixcolnum(1)
    ) u_ns (
        .clk(clk), .rst(rst), .TP(ns_tp), .tp_valid(ns_tv), .tp_ready(ns_tp_ready),
        .elem_data(ns_data), .elem_row(ns_row), .elem_col(ns_col),
        .elem_valid(ns_valid), .elem_ready(ns_er), .elem_last(ns_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack_words();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[N*W-1-i*W -: W] = words[i];
        return v;
    endfunction

    task automatic words_seq(input int base);
        for (int i = 0; i < N; i++) words[i] = W'(base + i);
    endtask

    task automatic words_rand();
        for (int i = 0; i < N; i++) words[i] = $urandom;
    endtask

    // One clock cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input bit tv, input bit er);
        elem_t e;
        bit    exp_rdy;
        bit    txp;
        bit    txe;
        @(negedge clk);
        tp_valid   = tv;
        elem_ready = er;
        if (tv) tp = pack_words();
        else for (int i = 0; i < N; i++) tp[i*W +: W] = $urandom;
        #1;
`ifdef KRON_READER_PRELOAD_EN
        exp_rdy = (q.size() <= N);
`else
        exp_rdy = (q.size() == 0);
`endif
        check_val("tp_ready", tp_ready, exp_rdy);
        check_val("elem_valid", elem_valid, q.size() != 0);
        seen_valid = elem_valid;
        if (q.size() != 0) begin
            e = q[0];
            check_val("elem_data", elem_data, e.d);
            check_val("elem_row", elem_row, e.r);
            check_val("elem_col", elem_col, e.c);
            check_val("elem_last", elem_last, e.last);
        end
        txp = tv && exp_rdy;
        txe = (q.size() != 0) && er;
        if (txe) void'(q.pop_front());
        if (txp) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    e.d    = words[r*C+c];
                    e.r    = r;
                    e.c    = c;
                    e.last = (r == R-1) && (c == C-1);
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 3*N && q.size() != 0; k++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_tp_ready"}, tp_ready, 0);
        check_val({tag, "_valid"}, elem_valid, 0);
        check_val({tag, "_last"}, elem_last, 0);
        check_val({tag, "_data"}, elem_data, 0);
        check_val({tag, "_row"}, elem_row, 0);
        check_val({tag, "_col"}, elem_col, 0);
        check_val({tag, "_ns_valid"}, ns_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        tp_valid   = 1'b0;
        elem_ready = 1'b0;
        #1;
        check_zero("rst_async");
        q.delete();
        @(negedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int idle_cnt;
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        tp         = '0;
        tp_valid   = 1'b0;
        elem_ready = 1'b0;
        ns_tp      = '0;
        ns_tv      = 1'b0;
        ns_er      = 1'b1;
        seen_valid = 1'b0;

        do_reset();

        // Basic stream 1..16 with elem_ready held high.
        words_seq(1);
        step(1'b1, 1'b1);
        drain();

        // Backpressure on element 5 for three cycles.
        words_seq(1);
        step(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        drain();

        // Reset while element 7 is presented, then restart.
        words_seq(1);
        step(1'b1, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        do_reset();
        words_seq(21);
        step(1'b1, 1'b1);
        drain();

        // Second matrix offered during streaming (accepted only with the shadow register).
        words_seq(1);
        step(1'b1, 1'b1);
        words_seq(101);
        step(1'b1, 1'b1);
        drain();

        // tp_valid held high: count idle cycles across three bursts.
        idle_cnt = 0;
        for (int k = 0; k < 3*N + 3; k++) begin
            words_rand();
            step(1'b1, 1'b1);
            if (!seen_valid) idle_cnt++;
        end
`ifdef KRON_READER_PRELOAD_EN
        check_val("idle_cycles", idle_cnt, 1);
`else
        check_val("idle_cycles", idle_cnt, 3);
`endif
        drain();

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            words_rand();
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
        end
        drain();

        // Non-square 3x2 product.
        @(negedge clk);
        for (int i = 0; i < 6; i++) ns_tp[6*W-1-i*W -: W] = W'(i + 1);
        ns_tv = 1'b1;
        #1;
        check_val("ns_tp_ready", ns_tp_ready, 1);
        @(negedge clk);
        ns_tv = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_val("ns_valid", ns_valid, 1);
            check_val("ns_data", ns_data, k + 1);
            check_val("ns_row", ns_row, k / 2);
            check_val("ns_col", ns_col, k % 2);
            check_val("ns_last", ns_last, k == 5);
            @(negedge clk);
        end
        #1;
        check_val("ns_done", ns_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
